// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the single-port RAM arbiter.
package ram_arb_pkg;

    // Transaction sequencer states; each transaction visits all three in order.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    // Cycles from accept (IDLE) to the earliest next accept.
    localparam int ACCESS_LATENCY = 3;

    // Index of the set bit in a one-hot vector (0 when the vector is zero).
    function automatic int unsigned onehot_to_idx(input logic [31:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) idx = unsigned'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: the search for a requester starts at ptr and
// wraps around. With ptr held at 0 it degenerates to fixed priority where
// index 0 wins.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant
);

    logic [IW:0] idx;
    logic        found;

    // Walk N slots starting at ptr; the first active request gets the grant.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = {1'b0, ptr} + (IW+1)'(k);
            if (idx >= (IW+1)'(N)) idx = idx - (IW+1)'(N);
            if (!found && req[idx[IW-1:0]]) begin
                grant[idx[IW-1:0]] = 1'b1;
                found              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter. Accepts one request at a time from N_REQ
// requesters, drives registered RAM strobes for one ACCESS cycle and returns
// a one-cycle response pulse to the owner.
// Optional feature: define RAM_ARB_ROUND_ROBIN_EN for round-robin arbitration;
// the default build uses fixed priority with index 0 highest.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int N_REQ      = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req_valid,
    output logic [N_REQ-1:0]            req_ready,
    input  logic [N_REQ-1:0]            req_we,
    input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [N_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]       rsp_rdata,
    output logic                        mem_cs,
    output logic                        mem_we,
    output logic                        mem_oe,
    output logic [ADDR_WIDTH-1:0]       mem_addr,
    output logic [DATA_WIDTH-1:0]       mem_wdata,
    output logic                        mem_drive,
    input  logic [DATA_WIDTH-1:0]       mem_rdata,
    output logic                        busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0][ADDR_WIDTH-1:0] addr_v;
    logic [N_REQ-1:0][DATA_WIDTH-1:0] wdata_v;
    arb_state_t                       state;
    logic [IDX_W-1:0]                 owner;
    logic [IDX_W-1:0]                 win_idx;
    logic [IDX_W-1:0]                 rr_ptr;
    logic [N_REQ-1:0]                 grant;
    logic                             any_req;

    assign addr_v  = req_addr;
    assign wdata_v = req_wdata;
    assign any_req = |req_valid;

    rr_arbiter #(
        .N  (N_REQ),
        .IW (IDX_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    assign win_idx = IDX_W'(onehot_to_idx(32'(grant)));

    // Accept only in IDLE and never while reset is held, so no handshake can
    // be lost to a flop that is being cleared.
    assign req_ready = (rst_n && state == IDLE) ? grant : '0;
    assign busy      = (state != IDLE);

    // Write data is driven only during a write access; oe is !we under cs, so
    // the RAM and the arbiter never drive the data pin together.
    assign mem_drive = mem_cs & mem_we;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    // Move the search start just past each winner so a waiting port is next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (state == IDLE && any_req) begin
            rr_ptr <= (win_idx == IDX_W'(N_REQ-1)) ? '0 : win_idx + IDX_W'(1);
        end
    end
`else
    assign rr_ptr = '0;
`endif

    // Transaction sequencer: latch the winner's payload into the strobes,
    // hold them for one ACCESS cycle, then pulse the owner's response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= '0;
            mem_cs    <= 1'b0;
            mem_we    <= 1'b0;
            mem_oe    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    rsp_valid <= '0;
                    if (any_req) begin
                        mem_cs    <= 1'b1;
                        mem_we    <= req_we[win_idx];
                        mem_oe    <= !req_we[win_idx];
                        mem_addr  <= addr_v[win_idx];
                        mem_wdata <= wdata_v[win_idx];
                        owner     <= win_idx;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Read data is valid on the pin by the closing edge;
                    // writes leave the last read value untouched.
                    if (!mem_we) rsp_rdata <= mem_rdata;
                    mem_cs    <= 1'b0;
                    mem_we    <= 1'b0;
                    mem_oe    <= 1'b0;
                    rsp_valid <= N_REQ'(1) << owner;
                    state     <= RESP;
                end
                RESP: begin
                    rsp_valid <= '0;
                    state     <= IDLE;
                end
                default: begin
                    mem_cs    <= 1'b0;
                    mem_we    <= 1'b0;
                    mem_oe    <= 1'b0;
                    rsp_valid <= '0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural RAM model. Unwritten RAM
// locations hold addr[7:0] ^ 8'hA5.
module tb_ram_arbiter;

    localparam int AW = 12;
    localparam int DW = 8;
    localparam int NR = 2;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NR-1:0]          req_valid, req_ready, req_we, rsp_valid;
    logic [NR-1:0][AW-1:0]  req_addr;
    logic [NR-1:0][DW-1:0]  req_wdata;
    logic [DW-1:0]          rsp_rdata, mem_wdata, mem_rdata;
    logic                   mem_cs, mem_we, mem_oe, mem_drive, busy;
    logic [AW-1:0]          mem_addr;
    logic                   ram_init;
    logic [DW-1:0]          ram [0:(1<<AW)-1];
    int                     cyc = 0;
    int                     n_checks = 0;
    int                     n_fail = 0;

    ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_REQ(NR)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_drive(mem_drive),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: commits writes on the rising edge under cs&we.
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < (1<<AW); i++) ram[i] <= DW'(i) ^ 8'hA5;
        end else if (mem_cs && mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
    end
    assign mem_rdata = (mem_cs && mem_oe) ? ram[mem_addr] : '0;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required finish before 500000 ns");
        $fatal(1, "watchdog expired");
    end

    task automatic set_req(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[p] = 1'b1;
        req_we[p]    = we;
        req_addr[p]  = a;
        req_wdata[p] = d;
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after accept.
    task automatic wait_accept(input int p, output int t_acc);
        t_acc = -1;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (req_ready[p]) begin
                t_acc = cyc;
                @(posedge clk); #1;
                req_valid[p] = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (t_acc < 0) begin
            n_fail++;
            req_valid[p] = 1'b0;
            $display("FAIL accept_timeout port %0d: got no req_ready, required within 20 cycles", p);
        end
    endtask

    // One full transaction; reports what was seen in T+1, T+2 and T+3.
    task automatic xact(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output logic [3:0] strb, output logic [AW-1:0] o_addr, output logic [DW-1:0] o_wdata,
                        output logic [3*NR-1:0] rsp_seq, output logic [DW-1:0] rdata);
        int t;
        logic [NR-1:0] r1;
        logic [NR-1:0] r2;
        set_req(p, we, a, d);
        wait_accept(p, t);
        strb    = {mem_cs, mem_we, mem_oe, mem_drive};
        o_addr  = mem_addr;
        o_wdata = mem_wdata;
        r1      = rsp_valid;
        @(posedge clk); #1;
        r2      = rsp_valid;
        rdata   = rsp_rdata;
        @(posedge clk); #1;
        rsp_seq = {r1, r2, rsp_valid};
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        ram_init     = 1'b0;
        req_valid    = 2'b11;
        req_we       = 2'b11;
        req_addr[0]  = 12'h123;
        req_wdata[0] = 8'h5A;
        #1;
        n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL rst_req_ready: got %b, required 00", req_ready); end
        n_checks++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL rst_rsp_valid: got %b, required 00", rsp_valid); end
        n_checks++; if (rsp_rdata !== 8'h00) begin n_fail++; $display("FAIL rst_rsp_rdata: got %h, required 00", rsp_rdata); end
        n_checks++; if ({mem_cs, mem_we, mem_oe, mem_drive} !== 4'b0000) begin n_fail++; $display("FAIL rst_strobes: got %b, required 0000", {mem_cs, mem_we, mem_oe, mem_drive}); end
        n_checks++; if ({mem_addr, mem_wdata} !== 20'h0) begin n_fail++; $display("FAIL rst_addr_data: got %h/%h, required 000/00", mem_addr, mem_wdata); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b, required 0", busy); end
        @(posedge clk); #1;
        n_checks++; if (mem_cs !== 1'b0) begin n_fail++; $display("FAIL rst_held_cs: got %b, required 0", mem_cs); end
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        rst_n     = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0 || req_ready !== 2'b00) begin n_fail++; $display("FAIL rst_release_idle: got busy=%b ready=%b, required 0/00", busy, req_ready); end
    endtask

    task automatic test_write_read();
        logic [3:0] s; logic [AW-1:0] oa; logic [DW-1:0] ow, rd; logic [3*NR-1:0] rs;
        xact(0, 1'b1, 12'h0A5, 8'h3C, s, oa, ow, rs, rd);
        n_checks++; if (s !== 4'b1101) begin n_fail++; $display("FAIL wr_strobes: got %b, required 1101", s); end
        n_checks++; if (oa !== 12'h0A5 || ow !== 8'h3C) begin n_fail++; $display("FAIL wr_payload: got %h/%h, required 0a5/3c", oa, ow); end
        n_checks++; if (rs !== 6'b00_01_00) begin n_fail++; $display("FAIL wr_rsp_timing: got %b, required 000100", rs); end
        xact(0, 1'b0, 12'h0A5, 8'h00, s, oa, ow, rs, rd);
        n_checks++; if (s !== 4'b1010) begin n_fail++; $display("FAIL rd_strobes: got %b, required 1010", s); end
        n_checks++; if (rs !== 6'b00_01_00) begin n_fail++; $display("FAIL rd_rsp_timing: got %b, required 000100", rs); end
        n_checks++; if (rd !== 8'h3C) begin n_fail++; $display("FAIL rd_data: got %h, required 3c", rd); end
        xact(1, 1'b1, 12'h0B0, 8'h77, s, oa, ow, rs, rd);
        n_checks++; if (rs !== 6'b00_10_00) begin n_fail++; $display("FAIL wr_port1_rsp: got %b, required 001000", rs); end
        n_checks++; if (rd !== 8'h3C) begin n_fail++; $display("FAIL rdata_hold_on_write: got %h, required 3c", rd); end
    endtask

    task automatic test_fixed_priority();
        set_req(0, 1'b0, 12'h001, 8'h00);
        set_req(1, 1'b0, 12'h002, 8'h00);
        #1;
        n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL prio_first_grant: got %b, required 01", req_ready); end
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        #1;
        n_checks++; if (req_ready !== 2'b00 || busy !== 1'b1) begin n_fail++; $display("FAIL prio_wait_in_access: got ready=%b busy=%b, required 00/1", req_ready, busy); end
        @(posedge clk); #1;
        n_checks++; if (rsp_valid !== 2'b01 || rsp_rdata !== 8'hA4) begin n_fail++; $display("FAIL prio_rsp0: got %b/%h, required 01/a4", rsp_valid, rsp_rdata); end
        @(posedge clk); #1;
        #1;
        n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL prio_second_grant: got %b, required 10", req_ready); end
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (rsp_valid !== 2'b10 || rsp_rdata !== 8'hA7) begin n_fail++; $display("FAIL prio_rsp1: got %b/%h, required 10/a7", rsp_valid, rsp_rdata); end
        @(posedge clk); #1;
    endtask

    task automatic test_starvation();
        logic [5:0] seq, exp_seq;
        int ng, last, mingap;
        seq = '0; ng = 0; last = -100; mingap = 100;
`ifdef RAM_ARB_ROUND_ROBIN_EN
        exp_seq = 6'b101010;
`else
        exp_seq = 6'b000000;
`endif
        set_req(0, 1'b0, 12'h010, 8'h00);
        set_req(1, 1'b0, 12'h020, 8'h00);
        for (int k = 0; k < 40 && ng < 6; k++) begin
            #1;
            if (|req_ready) begin
                seq[ng] = req_ready[1];
                if (ng > 0 && cyc - last < mingap) mingap = cyc - last;
                last = cyc;
                ng++;
            end
            @(posedge clk); #1;
        end
        req_valid = '0;
        repeat (3) begin @(posedge clk); #1; end
        n_checks++; if (ng !== 6) begin n_fail++; $display("FAIL starve_grant_count: got %0d, required 6", ng); end
        n_checks++; if (seq !== exp_seq) begin n_fail++; $display("FAIL starve_sequence: got %b, required %b", seq, exp_seq); end
        n_checks++; if (mingap !== 3) begin n_fail++; $display("FAIL starve_grant_spacing: got %0d, required 3", mingap); end
    endtask

    task automatic test_boundaries();
        logic [3:0] s; logic [AW-1:0] oa; logic [DW-1:0] ow, rd; logic [3*NR-1:0] rs;
        xact(0, 1'b1, 12'h000, 8'hFF, s, oa, ow, rs, rd);
        n_checks++; if (oa !== 12'h000) begin n_fail++; $display("FAIL bnd_wr_low_addr: got %h, required 000", oa); end
        xact(1, 1'b1, 12'hFFF, 8'h01, s, oa, ow, rs, rd);
        n_checks++; if (oa !== 12'hFFF || ow !== 8'h01) begin n_fail++; $display("FAIL bnd_wr_high: got %h/%h, required fff/01", oa, ow); end
        xact(1, 1'b0, 12'h000, 8'h00, s, oa, ow, rs, rd);
        n_checks++; if (rd !== 8'hFF || rs !== 6'b00_10_00) begin n_fail++; $display("FAIL bnd_rd_low: got %h/%b, required ff/001000", rd, rs); end
        xact(0, 1'b0, 12'hFFF, 8'h00, s, oa, ow, rs, rd);
        n_checks++; if (rd !== 8'h01 || oa !== 12'hFFF) begin n_fail++; $display("FAIL bnd_rd_high: got %h@%h, required 01@fff", rd, oa); end
    endtask

    task automatic test_reset_mid();
        int t; logic seen;
        logic [3:0] s; logic [AW-1:0] oa; logic [DW-1:0] ow, rd; logic [3*NR-1:0] rs;
        set_req(0, 1'b1, 12'h100, 8'h55);
        wait_accept(0, t);
        n_checks++; if (mem_cs !== 1'b1 || mem_we !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_access: got cs=%b we=%b, required 1/1", mem_cs, mem_we); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if ({mem_cs, mem_drive, busy} !== 3'b000) begin n_fail++; $display("FAIL rstmid_async_drop: got cs/drive/busy=%b, required 000", {mem_cs, mem_drive, busy}); end
        seen = 1'b0;
        repeat (2) begin @(posedge clk); #1; seen |= |rsp_valid; end
        rst_n = 1'b1;
        repeat (3) begin @(posedge clk); #1; seen |= |rsp_valid; end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_rsp: got rsp seen=%b, required 0", seen); end
        xact(0, 1'b0, 12'h100, 8'h00, s, oa, ow, rs, rd);
        n_checks++; if (rd !== 8'hA5) begin n_fail++; $display("FAIL rstmid_write_lost: got %h, required a5", rd); end
    endtask

    task automatic test_bus_safety();
        int last, due;
        logic [NR-1:0] exp_rsp, acc;
        last = -100; due = -1; exp_rsp = '0;
        for (int k = 0; k < 80; k++) begin
            for (int p = 0; p < NR; p++) begin
                if (!req_valid[p] && $urandom_range(0, 1) == 1)
                    set_req(p, 1'($urandom_range(0, 1)), 12'h200 + 12'($urandom_range(0, 15)), 8'($urandom));
            end
            #1;
            n_checks++; if (mem_drive & mem_oe) begin n_fail++; $display("FAIL bus_contention cyc %0d: got drive&oe=1, required 0", cyc); end
            n_checks++; if (!$onehot0(req_ready)) begin n_fail++; $display("FAIL ready_onehot cyc %0d: got %b, required one-hot or zero", cyc, req_ready); end
            n_checks++; if (rsp_valid !== ((cyc == due) ? exp_rsp : 2'b00)) begin n_fail++; $display("FAIL rand_rsp cyc %0d: got %b, required %b", cyc, rsp_valid, (cyc == due) ? exp_rsp : 2'b00); end
            acc = req_ready;
            if (|acc) begin
                n_checks++; if (cyc - last < 3) begin n_fail++; $display("FAIL grant_spacing cyc %0d: got %0d, required >=3", cyc, cyc - last); end
                last = cyc;
                due = cyc + 2;
                exp_rsp = acc;
            end
            @(posedge clk); #1;
            req_valid = req_valid & ~acc;
        end
        req_valid = '0;
        repeat (3) begin @(posedge clk); #1; end
    endtask

    initial begin
        rst_n     = 1'b0;
        ram_init  = 1'b1;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        test_reset();
        test_write_read();
        test_fixed_priority();
        test_starvation();
        test_boundaries();
        test_reset_mid();
        test_bus_safety();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port `ram` (cs / write_enable / oe, 12-bit address, 8-bit data) between N_REQ requesters, e.g. instruction fetch and data load/store.
- Accepts one request at a time through a valid/ready handshake and drives the RAM strobes from registers.
- Returns read data or a write acknowledge as a one-cycle response pulse to the granted requester.
- Sits between the CPU front/back end and the RAM instance; top level ties `mem_wdata`/`mem_rdata`/`mem_drive` to the RAM's bidirectional data pin.

Parameters:
- ADDR_WIDTH, 12, RAM address width.
- DATA_WIDTH, 8, RAM data width.
- N_REQ, 2, number of requesters (>=2); index 0 has highest fixed priority.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester accept pulse (one-hot or zero).
- req_we  in  N_REQ  1 = write, 0 = read.
- req_addr  in  N_REQ*ADDR_WIDTH  packed addresses; slot i is bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  N_REQ*DATA_WIDTH  packed write data.
- rsp_valid  out  N_REQ  one-cycle response pulse to the owner.
- rsp_rdata  out  DATA_WIDTH  read data; valid only with rsp_valid on a read.
- mem_cs  out  1  RAM chip select.
- mem_we  out  1  RAM write_enable.
- mem_oe  out  1  RAM output enable.
- mem_addr  out  ADDR_WIDTH  RAM address.
- mem_wdata  out  DATA_WIDTH  data to drive onto the RAM data pin.
- mem_drive  out  1  tristate enable for mem_wdata, equal to mem_cs & mem_we.
- mem_rdata  in  DATA_WIDTH  RAM data pin sampled value.
- busy  out  1  high whenever the FSM is not IDLE.

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE.
  - All outputs 0: req_ready, rsp_valid, rsp_rdata, mem_* strobes, mem_addr, mem_wdata, busy.
  - Owner register=0; round-robin pointer=0.
- FSM states: IDLE -> ACCESS -> RESP -> IDLE. Fixed 3-cycle occupancy per transaction; no pipelining.
- IDLE, cycle T:
  - If any req_valid, pick winner w combinationally; req_ready[w]=1 this cycle (handshake = valid & ready).
  - Register addr/wdata/we of w into mem_addr/mem_wdata/mem_we; set mem_cs=1 and mem_oe=!we; owner=w; go to ACCESS.
  - If no req_valid, stay in IDLE with all strobes 0.
- ACCESS, T+1:
  - Strobes are stable all cycle. The RAM commits a write at the closing rising edge; read data appears after the falling edge.
  - At the closing edge: capture mem_rdata into rsp_rdata (reads only; rsp_rdata holds its old value on writes); deassert mem_cs/mem_we/mem_oe; go to RESP.
- RESP, T+2:
  - rsp_valid[owner]=1 for exactly one cycle; go to IDLE.
  - The next request can be granted in T+3.
- Requester contract: hold req_valid and its payload stable until req_ready. Responses cannot be back-pressured.
- req_ready is never asserted outside IDLE; requests presented in ACCESS/RESP simply wait.
- Simultaneous requests: fixed priority, lowest index wins, unless RAM_ARB_ROUND_ROBIN_EN is defined.
- Address range: full 0 .. 2^ADDR_WIDTH-1. No wrap or translation; addresses pass through unchanged.
- Reset mid-operation: strobes drop immediately (asynchronously).
  - A write whose ACCESS cycle completes before rst_n falls is committed; otherwise it is lost.
  - No response is issued after reset.
- mem_drive must never be 1 while mem_oe=1, so there is no bus contention.

Optional Feature:
- Macro: RAM_ARB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration. The search starts at pointer p; on each grant, p becomes (w+1) mod N_REQ. A continuously requesting port waits at most N_REQ-1 grants.
- Undefined: strict fixed priority, index 0 highest; pointer logic is absent.

Decomposition:
- Package ram_arb_pkg holds:
  - enum `arb_state_t {IDLE, ACCESS, RESP}`;
  - localparam ACCESS_LATENCY=3;
  - function `onehot_to_idx`.
- Sub-module rr_arbiter (req vector in, one-hot grant out, pointer update input). Instantiated for both modes; the pointer is tied to 0 when RAM_ARB_ROUND_ROBIN_EN is undefined.

Test Plan:
- Write then read, single port: port 0 writes addr 0x0A5 data 0x3C, then reads 0x0A5.
  - Write: req_ready[0] in T, mem_cs&mem_we in T+1, rsp_valid[0] in T+2.
  - Read: rsp_rdata=0x3C with rsp_valid[0] 2 cycles after accept.
- Simultaneous reads, fixed priority: both ports request reads (0x001, 0x002) in the same cycle.
  - Port 0 is served first and port 1 is accepted 3 cycles later.
  - Each rsp_valid goes only to its own bit, with the correct data.
- Starvation check with RAM_ARB_ROUND_ROBIN_EN: both ports request continuously for 6 transactions.
  - Grants alternate 0,1,0,1,0,1.
  - Without the macro, port 0 gets all 6.
- Address boundaries: write and read back at addr 0x000 and 0xFFF (data 0xFF, 0x01). Both read back exactly; no aliasing.
- Reset mid-transaction: drop rst_n during ACCESS of a write to 0x100 (data 0x55).
  - mem_cs=0 and busy=0 immediately; no rsp_valid.
  - After release, a read of 0x100 returns its pre-write value.
- Bus safety: every cycle of a random mixed read/write run asserts !(mem_drive & mem_oe).
  - req_ready and rsp_valid are each one-hot-or-zero.
  - No two grants occur less than 3 cycles apart.
